// File: rtl/csa_resolver_if.sv
// Handshake bundle between a carry-save source, the resolver and its consumer.
interface csa_resolver_if #(
    parameter int WIDTH = 4
);
    localparam int ITER_W = $clog2(WIDTH + 3);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  Sum_in;
    logic [WIDTH-1:0]  Cout_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH+1:0]  Result;
    logic [ITER_W-1:0] Iter;
    logic              busy;

    // Source and consumer side
    modport master (
        output in_valid, Sum_in, Cout_in, out_ready,
        input  in_ready, out_valid, Result, Iter, busy
    );

    // Resolver side
    modport slave (
        input  in_valid, Sum_in, Cout_in, out_ready,
        output in_ready, out_valid, Result, Iter, busy
    );
endinterface

// File: rtl/csa_resolver.sv
// Iterative carry-save to binary resolver: one XOR/AND carry-save step per
// clock until the carry vector is empty, then presents S as the result.
module csa_resolver #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    csa_resolver_if.slave bus
);
    localparam int ITER_W = $clog2(WIDTH + 3);
    localparam int RW     = WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [RW-1:0]     r_s;
    logic [RW-1:0]     r_c;
    logic [RW-1:0]     r_result;
    logic [ITER_W-1:0] r_iter;
    logic              w_accept;
    logic              w_consume;
    logic              w_c_zero;

    // Partial-sum half of a carry-save step
    function automatic logic [RW-1:0] f_sum_step(input logic [RW-1:0] s,
                                                 input logic [RW-1:0] c);
        return s ^ c;
    endfunction

    // Carry half of a carry-save step; the top bit can never be set, so
    // truncating to RW bits loses nothing
    function automatic logic [RW-1:0] f_carry_step(input logic [RW-1:0] s,
                                                   input logic [RW-1:0] c);
        return (s & c) << 1;
    endfunction

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_consume = bus.out_ready && (r_state == ST_DONE);
    assign w_c_zero  = (r_c == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept)  w_next = ST_RESOLVE;
            ST_RESOLVE: if (w_c_zero)  w_next = ST_DONE;
            ST_DONE:    if (w_consume) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Carry-save working registers and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_c    <= '0;
            r_iter <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_s    <= {2'b00, bus.Sum_in};
                        r_c    <= {1'b0, bus.Cout_in, 1'b0};
                        r_iter <= '0;
                    end
                end
                ST_RESOLVE: begin
                    if (!w_c_zero) begin
                        r_s    <= f_sum_step(r_s, r_c);
                        r_c    <= f_carry_step(r_s, r_c);
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered result: captures S when resolution finishes, clears on handover
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (r_state == ST_RESOLVE && w_c_zero) begin
            r_result <= r_s;
        end else if (w_consume) begin
            r_result <= '0;
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_DONE);
        bus.busy      = (r_state != ST_IDLE);
        bus.Result    = r_result;
        bus.Iter      = r_iter;
    end
endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: directed cases on a 4-bit instance, random
// handshaking on an 8-bit instance, expected results kept in scoreboards.
module tb_csa_resolver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csa_resolver_if #(.WIDTH(4)) b4 ();
    csa_resolver_if #(.WIDTH(8)) b8 ();

    csa_resolver #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
    csa_resolver #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        int res;
        int iter;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Step count of the carry-save recurrence, computed on plain integers
    function automatic int model_iter(input int s_in, input int c_in, input int w);
        int s = s_in;
        int c = (c_in << 1);
        int n = 0;
        int mask = (1 << (w + 2)) - 1;
        while (c != 0 && n < 64) begin
            int t = s;
            s = (s ^ c) & mask;
            c = ((t & c) << 1) & mask;
            n++;
        end
        return n;
    endfunction

    // Present a pair on the 4-bit instance; returns at the negedge after the accepting edge
    task automatic send4(input int s, input int c, input int exp_res, input int exp_iter);
        int n = 0;
        exp_t e;
        @(negedge clk);
        b4.in_valid = 1'b1;
        b4.Sum_in   = 4'(s);
        b4.Cout_in  = 4'(c);
        while (!b4.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b4.in_ready) check("send4_timeout", 0, 1);
        e.res  = exp_res;
        e.iter = exp_iter;
        q4.push_back(e);
        @(negedge clk);
        b4.in_valid = 1'b0;
    endtask

    // Wait for out_valid, counting edges from the accepting edge inclusive
    task automatic wait_out4(input string tag, input int exp_lat);
        int lat = 1;
        exp_t e;
        while (!b4.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, b4.out_valid, 1);
        check({tag, "_lat"}, lat, exp_lat);
        if (q4.size() == 0) begin
            check({tag, "_q_empty"}, 0, 1);
        end else begin
            e = q4.pop_front();
            check({tag, "_res"}, b4.Result, e.res);
            check({tag, "_iter"}, b4.Iter, e.iter);
        end
        check({tag, "_busy"}, b4.busy, 1);
    endtask

    // Consume the pending result and confirm return to IDLE
    task automatic consume4(input string tag);
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
        check({tag, "_ov_clr"}, b4.out_valid, 0);
        check({tag, "_ir_set"}, b4.in_ready, 1);
        check({tag, "_res_clr"}, b4.Result, 0);
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        bit pending;
        int hold_res;
        int hold_iter;
        exp_t e;

        b4.in_valid = 1'b0; b4.Sum_in = '0; b4.Cout_in = '0; b4.out_ready = 1'b0;
        b8.in_valid = 1'b0; b8.Sum_in = '0; b8.Cout_in = '0; b8.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", b4.in_ready, 1);
        check("rst_out_valid", b4.out_valid, 0);
        check("rst_busy", b4.busy, 0);
        check("rst_result", b4.Result, 0);
        check("rst_iter", b4.Iter, 0);
        check("rst8_in_ready", b8.in_ready, 1);
        check("rst8_result", b8.Result, 0);

        // Directed cases
        send4(5, 3, 11, 2);
        check("c1_in_ready_busy", b4.in_ready, 0);
        wait_out4("c1", 4);
        consume4("c1");

        send4(9, 0, 9, 0);
        wait_out4("c2", 2);
        consume4("c2");

        send4(15, 1, 17, 4);
        wait_out4("c3a", 6);
        consume4("c3a");

        send4(15, 15, 45, 3);
        wait_out4("c3b", 5);
        consume4("c3b");

        // Backpressure: hold the result for five cycles
        send4(5, 3, 11, 2);
        wait_out4("c4", 4);
        hold_res  = b4.Result;
        hold_iter = b4.Iter;
        b4.in_valid = 1'b1;
        b4.Sum_in   = 4'h9;
        b4.Cout_in  = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("c4_hold_valid", b4.out_valid, 1);
            check("c4_hold_res", b4.Result, hold_res);
            check("c4_hold_iter", b4.Iter, hold_iter);
            check("c4_hold_in_ready", b4.in_ready, 0);
        end
        b4.in_valid = 1'b0;
        consume4("c4");

        // Reset in the middle of resolving the ripple case
        send4(15, 1, 17, 4);
        @(negedge clk);
        check("c5_busy_pre", b4.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(q4.pop_back());
        check("c5_in_ready", b4.in_ready, 1);
        check("c5_out_valid", b4.out_valid, 0);
        check("c5_result", b4.Result, 0);
        check("c5_iter", b4.Iter, 0);
        check("c5_busy", b4.busy, 0);
        send4(5, 3, 11, 2);
        wait_out4("c5_after", 4);
        consume4("c5_after");
        check("dir_q_drained", q4.size(), 0);

        // Random traffic on the 8-bit instance
        sent = 0; recv = 0; cyc = 0; pending = 1'b0;
        while (recv < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!pending) begin
                if (sent < 1000 && $urandom_range(3) != 0) begin
                    b8.Sum_in   = 8'($urandom_range(255));
                    b8.Cout_in  = 8'($urandom_range(255));
                    b8.in_valid = 1'b1;
                    pending     = 1'b1;
                end else begin
                    b8.in_valid = 1'b0;
                end
            end
            b8.out_ready = ($urandom_range(2) != 0);
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) begin
                    check("rnd_q_empty", 0, 1);
                end else begin
                    e = q8.pop_front();
                    check("rnd_res", b8.Result, e.res);
                    check("rnd_iter", b8.Iter, e.iter);
                    check("rnd_iter_bound", (b8.Iter <= 9), 1);
                end
                recv++;
            end
            if (b8.in_valid && b8.in_ready) begin
                e.res  = int'(b8.Sum_in) + 2 * int'(b8.Cout_in);
                e.iter = model_iter(int'(b8.Sum_in), int'(b8.Cout_in), 8);
                q8.push_back(e);
                sent++;
                pending = 1'b0;
            end
        end
        @(negedge clk);
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b0;
        check("rnd_recv_count", recv, 1000);
        check("rnd_q_drained", q8.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
